danger_response: RTL and testbench
==================================

# danger_response

Downstream consumer of the random danger generator in the pseudo-terminal game. It watches the `danger_out` level and opens a timed response window, scored in whole seconds. It grades the player's terminal command (escape or fight), or a timeout, and updates health and score. It then drives `danger_clear` back to the generator's reset so the next hazard can arm.

## Interface
- `TIMEOUT_SEC`, 5: seconds allowed in the window before an automatic hit; range 2..15.
- `MAX_HEALTH`, 3: health loaded on reset; range 1..3.
- `ESCAPE_OP`, 11'b00010000000: op_code that means "escape".
- `FIGHT_OP`, 11'b01000000000: op_code that means "fight".
- `QUICK_SEC`, 2: a fight is a win only if `reaction_sec` < `QUICK_SEC`.
- `clock_divide_sec` in 1: 1 Hz tick clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `danger_in` in 1: the generator's danger level.
- `op_code` in 11: the decoded terminal command, level-held by the terminal until the next command.
- `alarm` out 1: high while in ALERT.
- `danger_clear` out 1: drives the generator's reset.
- `reaction_sec` out 4: seconds taken by the last resolved event.
- `health` out 2: remaining health.
- `score` out 8: saturating score.
- `game_over` out 1: high in DEAD.

## Operation
- Reset values: state = IDLE, `alarm` = 0, `danger_clear` = 1 (holds the generator cleared), `reaction_sec` = 0, `health` = `MAX_HEALTH`, `score` = 0, `game_over` = 0, timer = 0.
- `danger_s` is the sampled danger level (see Configuration).
- **IDLE:**
  - `danger_clear` = 0.
  - If `danger_s` = 1: go to ALERT, timer = 0.
- **ALERT:**
  - `alarm` = 1. The timer increments by 1 on every tick.
  - The op_code is checked before the timeout, so a command wins when both occur on the same tick.
  - op_code = `ESCAPE_OP`: `score` += 1; `reaction_sec` = timer; go to RESOLVE.
  - op_code = `FIGHT_OP` and timer < `QUICK_SEC`: `score` += 2; `reaction_sec` = timer; go to RESOLVE.
  - op_code = `FIGHT_OP` and timer ≥ `QUICK_SEC`: `health` −= 1; `reaction_sec` = timer; go to RESOLVE.
  - Otherwise, timer = `TIMEOUT_SEC`−1: `health` −= 1; `reaction_sec` = `TIMEOUT_SEC`; go to RESOLVE.
  - Any other op_code value is ignored.
- **RESOLVE:**
  - `danger_clear` = 1.
  - Stay until `danger_s` = 0, then go to IDLE.
  - If `health` = 0, go to DEAD instead of IDLE.
- **DEAD:**
  - `game_over` = 1, `danger_clear` = 1, `alarm` = 0.
  - Absorbing; only `reset` exits.
- **Arithmetic:**
  - `score` saturates at 255; an addition that would pass 255 leaves 255.
  - `health` never goes below 0.
  - Timer is 4 bits and never wraps, because the window ends at `TIMEOUT_SEC`−1.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronously), from any state.

## Timing
- All state changes occur on the rising edge of `clock_divide_sec`. All outputs are registered.
- Detection latency, `danger_in` rising to `alarm` = 1:
  - with synchroniser: 3rd tick edge;
  - without: 1st tick edge.
- Response latency: a command present at edge N moves the block to RESOLVE at edge N. `danger_clear` = 1 is visible after edge N.
- Because `op_code` is a held level, a command already held when ALERT is entered is graded at the first ALERT edge, with `reaction_sec` = 0.
- RESOLVE lasts at least 1 tick. With the synchroniser it lasts at least 3 ticks, until the cleared danger level propagates through.

## Configuration
- `DANGER_SYNC_EN` defined:
  - `danger_in` passes through a two-flop synchroniser on `clock_divide_sec`, reset to 0.
  - `danger_s` = second flop.
- `DANGER_SYNC_EN` undefined:
  - `danger_s` = `danger_in`, sampled directly.
  - The caller guarantees `danger_in` comes from the same tick domain.

## Structure
- Shared package `danger_pkg` holds:
  - state encoding, 2 bits: IDLE, ALERT, RESOLVE, DEAD;
  - default opcode constants `ESCAPE_OP` and `FIGHT_OP`;
  - the score width and the saturation limit.
- One sub-module, `sync_2ff`: 1-bit synchroniser with asynchronous reset. It is instantiated only under `DANGER_SYNC_EN`.

## Test plan
- Escape test:
  - Stimulus: reset; raise `danger_in`; hold op_code = `ESCAPE_OP` from tick 1 of ALERT.
  - Required: `score` = 1, `reaction_sec` = 1, `health` = 3, `danger_clear` pulses; state returns to IDLE after `danger_in` drops.
- Quick fight test:
  - Stimulus: `FIGHT_OP` at timer 0.
  - Required: `score` = 2, `reaction_sec` = 0.
- Slow fight test:
  - Stimulus: `FIGHT_OP` at timer 3.
  - Required: `health` = 2, `score` unchanged.
- Timeout test:
  - Stimulus: no command for 5 ticks in ALERT.
  - Required: `health` decrements, `reaction_sec` = 5.
  - Stimulus: repeat until `health` = 0.
  - Required: DEAD, `game_over` = 1, `danger_clear` = 1 held.
- Edge cases:
  - Stimulus: command on the same tick as the timeout.
  - Required: the command is graded, not the timeout.
  - Stimulus: `score` = 254, then a quick fight.
  - Required: `score` = 255.
- Reset test:
  - Stimulus: async `reset` asserted mid-ALERT, between tick edges.
  - Required: outputs take their reset values immediately.

Source files
------------

// File: rtl/danger_pkg.sv
// Shared definitions for the danger response block: state encoding, default
// command opcodes, score width and saturation helpers.
package danger_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ALERT   = 2'd1,
        S_RESOLVE = 2'd2,
        S_DEAD    = 2'd3
    } state_t;

    localparam int OP_W    = 11;
    localparam int SCORE_W = 8;
    localparam int TIMER_W = 4;

    localparam logic [OP_W-1:0]    DEFAULT_ESCAPE_OP = 11'b00010000000;
    localparam logic [OP_W-1:0]    DEFAULT_FIGHT_OP  = 11'b01000000000;
    localparam logic [SCORE_W-1:0] SCORE_MAX         = 8'd255;

    // Adds a small bonus to the score, clamping at SCORE_MAX instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] score,
                                                     input logic [1:0] bonus);
        logic [SCORE_W:0] sum;
        sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, bonus};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [1:0] health_dec(input logic [1:0] health);
        return (health == 2'd0) ? 2'd0 : health - 2'd1;
    endfunction

endpackage

// File: rtl/danger_response_sync_2ff.sv
// Two-flop synchroniser for the danger level, clocked by the 1 Hz tick and
// cleared asynchronously to 0.
module sync_2ff (
    input  logic clock_divide_sec,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops use non-blocking assignments so meta and q update together;
    // blocking here would collapse the two stages into one.
    always_ff @(posedge clock_divide_sec or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/danger_response.sv
// Grades the player's response to a danger event and keeps health and score.
// Define DANGER_SYNC_EN to route danger_in through a two-flop synchroniser.
module danger_response
    import danger_pkg::*;
#(
    parameter int              TIMEOUT_SEC = 5,
    parameter int              MAX_HEALTH  = 3,
    parameter logic [OP_W-1:0] ESCAPE_OP   = DEFAULT_ESCAPE_OP,
    parameter logic [OP_W-1:0] FIGHT_OP    = DEFAULT_FIGHT_OP,
    parameter int              QUICK_SEC   = 2
) (
    input  logic               clock_divide_sec,
    input  logic               reset,
    input  logic               danger_in,
    input  logic [OP_W-1:0]    op_code,
    output logic               alarm,
    output logic               danger_clear,
    output logic [3:0]         reaction_sec,
    output logic [1:0]         health,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_SEC - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_VAL  = TIMER_W'(TIMEOUT_SEC);
    localparam logic [TIMER_W-1:0] QUICK_LIMIT  = TIMER_W'(QUICK_SEC);
    localparam logic [1:0]         HEALTH_INIT  = 2'(MAX_HEALTH);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               danger_s;
    logic               is_escape;
    logic               is_fight;

`ifdef DANGER_SYNC_EN
    sync_2ff u_sync (
        .clock_divide_sec (clock_divide_sec),
        .reset            (reset),
        .d                (danger_in),
        .q                (danger_s)
    );
`else
    assign danger_s = danger_in;
`endif

    assign is_escape = (op_code == ESCAPE_OP);
    assign is_fight  = (op_code == FIGHT_OP);

    always_ff @(posedge clock_divide_sec or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            alarm        <= 1'b0;
            danger_clear <= 1'b1;
            reaction_sec <= '0;
            health       <= HEALTH_INIT;
            score        <= '0;
            game_over    <= 1'b0;
            timer        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    danger_clear <= 1'b0;
                    if (danger_s) begin
                        state <= S_ALERT;
                        alarm <= 1'b1;
                        timer <= '0;
                    end
                end

                S_ALERT: begin
                    timer <= timer + 1'b1;
                    // A command takes priority over a timeout on the same tick.
                    if (is_escape || is_fight || timer == TIMEOUT_LAST) begin
                        state        <= S_RESOLVE;
                        alarm        <= 1'b0;
                        danger_clear <= 1'b1;
                        if (is_escape) begin
                            score        <= score_add(score, 2'd1);
                            reaction_sec <= timer;
                        end else if (is_fight) begin
                            if (timer < QUICK_LIMIT) score <= score_add(score, 2'd2);
                            else                     health <= health_dec(health);
                            reaction_sec <= timer;
                        end else begin
                            health       <= health_dec(health);
                            reaction_sec <= TIMEOUT_VAL;
                        end
                    end
                end

                S_RESOLVE: begin
                    danger_clear <= 1'b1;
                    if (!danger_s) begin
                        if (health == 2'd0) begin
                            state     <= S_DEAD;
                            game_over <= 1'b1;
                        end else begin
                            state        <= S_IDLE;
                            danger_clear <= 1'b0;
                        end
                    end
                end

                S_DEAD: begin
                    game_over    <= 1'b1;
                    danger_clear <= 1'b1;
                    alarm        <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_danger_response.sv
// Randomised bench for danger_response (default build, no synchroniser),
// checked against a per-event model of health, score and reaction time.
module tb_danger_response;

    localparam logic [10:0] ESC   = 11'b00010000000;
    localparam logic [10:0] FIGHT = 11'b01000000000;
    localparam int          TMO   = 5;
    localparam int          QUICK = 2;
    localparam int          MAXH  = 3;

    logic        clock_divide_sec = 1'b0;
    logic        reset = 1'b0;
    logic        danger_in = 1'b0;
    logic [10:0] op_code = '0;
    logic        alarm, danger_clear, game_over;
    logic [3:0]  reaction_sec;
    logic [1:0]  health;
    logic [7:0]  score;

    int vectors = 0;
    int miscompares = 0;
    int m_health = MAXH;
    int m_score = 0;

    danger_response dut (
        .clock_divide_sec (clock_divide_sec),
        .reset            (reset),
        .danger_in        (danger_in),
        .op_code          (op_code),
        .alarm            (alarm),
        .danger_clear     (danger_clear),
        .reaction_sec     (reaction_sec),
        .health           (health),
        .score            (score),
        .game_over        (game_over)
    );

    always #5 clock_divide_sec = ~clock_divide_sec;

    function automatic logic [10:0] other_op();
        logic [10:0] v;
        do v = 11'($urandom_range(2047)); while (v == ESC || v == FIGHT);
        return v;
    endfunction

    task automatic test_reset();
        @(negedge clock_divide_sec);
        #2 reset = 1'b1;
        danger_in = 1'b0;
        op_code = '0;
        #1;
        vectors++;
        if ({alarm, danger_clear, game_over} !== 3'b010 || reaction_sec !== 4'd0 ||
            health !== 2'(MAXH) || score !== 8'd0) begin
            miscompares++;
            $display("FAIL reset: alarm=%b clear=%b over=%b react=%0d health=%0d score=%0d, want 0 1 0 0 %0d 0",
                     alarm, danger_clear, game_over, reaction_sec, health, score, MAXH);
        end
        @(negedge clock_divide_sec);
        reset = 1'b0;
        m_health = MAXH;
        m_score = 0;
    endtask

    // One hazard: cmd 0=none 1=escape 2=fight, presented so it is graded at
    // timer t; danger_in held for `hold` extra ticks in RESOLVE.
    task automatic run_event(input int cmd, input int t, input int hold);
        logic [10:0] cmd_op;
        bit apply;
        int edges, exp_edges, exp_react;
        cmd_op = (cmd == 1) ? ESC : FIGHT;
        apply = (cmd != 0) && (t <= TMO - 1);
        if (apply) begin
            exp_react = t;
            exp_edges = t + 1;
            if (cmd == 1)        m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
            else if (t < QUICK)  m_score = (m_score + 2 > 255) ? 255 : m_score + 2;
            else if (m_health > 0) m_health--;
        end else begin
            exp_react = TMO;
            exp_edges = TMO;
            if (m_health > 0) m_health--;
        end

        @(negedge clock_divide_sec);
        danger_in = 1'b1;
        op_code = (apply && t == 0) ? cmd_op : other_op();
        @(negedge clock_divide_sec);
        vectors++;
        if (alarm !== 1'b1 || danger_clear !== 1'b0) begin
            miscompares++;
            $display("FAIL detect: alarm=%b clear=%b, want 1 0", alarm, danger_clear);
        end
        edges = 0;
        while (alarm === 1'b1 && edges < 20) begin
            op_code = (apply && edges >= t) ? cmd_op : other_op();
            @(negedge clock_divide_sec);
            edges++;
        end
        vectors++;
        if (edges != exp_edges) begin
            miscompares++;
            $display("FAIL alert_len: %0d ticks, want %0d (cmd=%0d t=%0d)", edges, exp_edges, cmd, t);
        end
        vectors++;
        if (reaction_sec !== 4'(exp_react) || health !== 2'(m_health) || score !== 8'(m_score) ||
            danger_clear !== 1'b1 || game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL grade: react=%0d health=%0d score=%0d clear=%b over=%b, want %0d %0d %0d 1 0 (cmd=%0d t=%0d)",
                     reaction_sec, health, score, danger_clear, game_over,
                     exp_react, m_health, m_score, cmd, t);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clock_divide_sec);
            vectors++;
            if (danger_clear !== 1'b1 || alarm !== 1'b0 || game_over !== 1'b0) begin
                miscompares++;
                $display("FAIL resolve_hold: clear=%b alarm=%b over=%b, want 1 0 0",
                         danger_clear, alarm, game_over);
            end
        end
        danger_in = 1'b0;
        op_code = '0;
        @(negedge clock_divide_sec);
        vectors++;
        if (m_health == 0) begin
            if (game_over !== 1'b1 || danger_clear !== 1'b1 || alarm !== 1'b0) begin
                miscompares++;
                $display("FAIL dead_entry: over=%b clear=%b alarm=%b, want 1 1 0",
                         game_over, danger_clear, alarm);
            end
        end else if (game_over !== 1'b0 || danger_clear !== 1'b0 || alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_return: over=%b clear=%b alarm=%b, want 0 0 0",
                     game_over, danger_clear, alarm);
        end
    endtask

    task automatic test_escape();
        test_reset();
        run_event(1, 1, 1);
    endtask

    task automatic test_fights();
        run_event(2, 0, 0);
        run_event(2, 3, 0);
        run_event(2, 1, 2);
    endtask

    task automatic test_same_tick();
        test_reset();
        run_event(1, TMO - 1, 0);
        run_event(2, TMO - 1, 0);
    endtask

    task automatic test_timeout_to_dead();
        test_reset();
        while (m_health > 0) run_event(0, TMO + 1, $urandom_range(2));
        danger_in = 1'b1;
        op_code = ESC;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_divide_sec);
            vectors++;
            if (game_over !== 1'b1 || danger_clear !== 1'b1 || alarm !== 1'b0 || health !== 2'd0) begin
                miscompares++;
                $display("FAIL dead_absorb: over=%b clear=%b alarm=%b health=%0d, want 1 1 0 0",
                         game_over, danger_clear, alarm, health);
            end
        end
        danger_in = 1'b0;
    endtask

    task automatic test_saturation();
        test_reset();
        for (int i = 0; i < 127; i++) run_event(2, $urandom_range(1), 0);
        run_event(2, 0, 0);
        run_event(1, 2, 0);
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 60; i++) begin
            if (m_health == 0) test_reset();
            run_event($urandom_range(2), $urandom_range(6), $urandom_range(2));
        end
    endtask

    task automatic test_reset_mid_alert();
        test_reset();
        run_event(1, 2, 0);
        run_event(2, 3, 0);
        @(negedge clock_divide_sec);
        danger_in = 1'b1;
        @(negedge clock_divide_sec);
        @(negedge clock_divide_sec);
        #3 reset = 1'b1;
        #1;
        vectors++;
        if ({alarm, danger_clear, game_over} !== 3'b010 || reaction_sec !== 4'd0 ||
            health !== 2'(MAXH) || score !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_alert: alarm=%b clear=%b over=%b react=%0d health=%0d score=%0d, want 0 1 0 0 %0d 0",
                     alarm, danger_clear, game_over, reaction_sec, health, score, MAXH);
        end
        danger_in = 1'b0;
        @(negedge clock_divide_sec);
        reset = 1'b0;
        m_health = MAXH;
        m_score = 0;
        run_event(2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_escape();
        test_fights();
        test_same_tick();
        test_timeout_to_dead();
        test_saturation();
        test_random();
        test_reset_mid_alert();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
